// File: rtl/execute_stage_md_pkg.sv
// execute_stage_md shared types: control bundle, ALU/M-op encodings,
// forwarding selects and the M-unit FSM states.
package execute_stage_md_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF     = 2'd0,
    FWD_EX_MEM = 2'd1,
    FWD_MEM_WB = 2'd2
  } mux_control_type;

  typedef struct packed {
    alu_op_e ALUOp;
    logic    ALUSrc;
    logic    RegWrite;
    logic    MemWrite;
    logic    MemRead;
    logic    MemtoReg;
    logic    Branch;
  } control_type;

  // Sliced to XLEN by users.
  localparam logic [63:0] MD_DIV_ZERO_Q = '1;

endpackage

// File: rtl/execute_stage_md_muldiv_unit.sv
// muldiv_unit: iterative RV32M unit, shift-add multiply and restoring
// divide on operand magnitudes with sign correction in DONE.
// Ports: clk, rst (async high), flush_i, start_i, op_i, a_i, b_i,
//        stall_o, busy_o, done_o, result_o.
// MD_FAST_MUL_EN: MUL* ops use a one-shot combinational multiply.
module muldiv_unit
  import execute_stage_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            start_i,
  input  md_op_e          op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);

  md_state_e         state_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] p_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  md_op_e            op_q;
  logic              neg_a_q;
  logic              neg_b_q;

  logic            go;
  logic            sa, sb, na, nb;
  logic [XLEN-1:0] am, bm;

  assign go = start_i & ~flush_i & ~rst;

  // MUL low half is sign-agnostic, so it runs unsigned.
  assign sa = (op_i == MD_MULH) | (op_i == MD_MULHSU)
            | (op_i == MD_DIV)  | (op_i == MD_REM);
  assign sb = (op_i == MD_MULH) | (op_i == MD_DIV)
            | (op_i == MD_REM);
  assign na = sa & a_i[XLEN-1];
  assign nb = sb & b_i[XLEN-1];
  assign am = na ? -a_i : a_i;
  assign bm = nb ? -b_i : b_i;

`ifdef MD_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_p;
  assign fast_p = {{XLEN{1'b0}}, am} * {{XLEN{1'b0}}, bm};
`endif

  // p_q: upper half = partial product / remainder,
  // lower half = multiplier / dividend-quotient.
  logic [XLEN:0]     msum, dtry, dsub;
  logic              dge;
  logic [2*XLEN-1:0] p_step;

  always_comb begin
    msum = {1'b0, p_q[2*XLEN-1:XLEN]}
         + {1'b0, (p_q[0] ? b_q : {XLEN{1'b0}})};
    dtry = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
    dge  = dtry >= {1'b0, b_q};
    dsub = dtry - {1'b0, b_q};
    if (op_q[2])
      p_step = {(dge ? dsub[XLEN-1:0] : dtry[XLEN-1:0]),
                p_q[XLEN-2:0], dge};
    else
      p_step = {msum, p_q[XLEN-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= MD_MUL;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (go) begin
            a_q     <= a_i;
            b_q     <= bm;
            op_q    <= op_i;
            neg_a_q <= na;
            neg_b_q <= nb;
            cnt_q   <= CW'(XLEN-1);
            p_q     <= {{XLEN{1'b0}}, am};
            state_q <= BUSY;
`ifdef MD_FAST_MUL_EN
            if (!op_i[2]) begin
              p_q     <= fast_p;
              state_q <= DONE;
            end
`endif
          end
        end
        BUSY: begin
          p_q <= p_step;
          if (cnt_q == '0) state_q <= DONE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  logic              bz;

  always_comb begin
    prod = (neg_a_q ^ neg_b_q) ? -p_q : p_q;
    quo  = (neg_a_q ^ neg_b_q) ? -p_q[XLEN-1:0] : p_q[XLEN-1:0];
    rem  = neg_a_q ? -p_q[2*XLEN-1:XLEN] : p_q[2*XLEN-1:XLEN];
    bz   = b_q == '0;
    unique case (op_q)
      MD_MUL:               result_o = prod[XLEN-1:0];
      MD_DIV, MD_DIVU:      result_o = bz ? MD_DIV_ZERO_Q[XLEN-1:0] : quo;
      MD_REM, MD_REMU:      result_o = bz ? a_q : rem;
      default:              result_o = prod[2*XLEN-1:XLEN];
    endcase
  end

  assign stall_o = (state_q == BUSY) | ((state_q == IDLE) & go);
  assign busy_o  = state_q != IDLE;
  assign done_o  = (state_q == DONE) & ~flush_i;

endmodule

// File: rtl/execute_stage_md.sv
// execute_stage_md: EX stage with forwarding, single-cycle ALU and an
// iterative M-extension unit that stalls the pipeline while busy.
// Ports: clk, rst, flush, pc, control_in, md_en, md_op, data1/2,
//        immediate_data, rd_in, rs1/2, downstream rd/RegWrite/forward
//        values -> control_out, ZeroFlag, alu_data, memory_data,
//        rd_out, pc_out, stall, md_busy.
// MD_FAST_MUL_EN: single-cycle-capture multiply for MUL* ops.
module execute_stage_md
  import execute_stage_md_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [XLEN-1:0]       pc,
  input  control_type           control_in,
  input  logic                  md_en,
  input  logic [2:0]            md_op,
  input  logic [XLEN-1:0]       data1,
  input  logic [XLEN-1:0]       data2,
  input  logic [XLEN-1:0]       immediate_data,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd,
  input  logic [REG_ADDR_W-1:0] mem_wb_rd,
  input  logic                  ex_mem_RegWrite,
  input  logic                  mem_wb_RegWrite,
  input  logic [XLEN-1:0]       forward_ex_mem,
  input  logic [XLEN-1:0]       forward_mem_wb,
  output control_type           control_out,
  output logic                  ZeroFlag,
  output logic [XLEN-1:0]       alu_data,
  output logic [XLEN-1:0]       memory_data,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [XLEN-1:0]       pc_out,
  output logic                  stall,
  output logic                  md_busy
);

  localparam int SW = $clog2(XLEN);

  mux_control_type fa_sel, fb_sel;
  logic [XLEN-1:0] op_a, op_b_fwd, op_b;

  always_comb begin
    fa_sel = FWD_RF;
    if (ex_mem_RegWrite && ex_mem_rd != '0 && ex_mem_rd == rs1)
      fa_sel = FWD_EX_MEM;
    else if (mem_wb_RegWrite && mem_wb_rd != '0 && mem_wb_rd == rs1)
      fa_sel = FWD_MEM_WB;
    fb_sel = FWD_RF;
    if (ex_mem_RegWrite && ex_mem_rd != '0 && ex_mem_rd == rs2)
      fb_sel = FWD_EX_MEM;
    else if (mem_wb_RegWrite && mem_wb_rd != '0 && mem_wb_rd == rs2)
      fb_sel = FWD_MEM_WB;
  end

  always_comb begin
    unique case (fa_sel)
      FWD_EX_MEM: op_a = forward_ex_mem;
      FWD_MEM_WB: op_a = forward_mem_wb;
      default:    op_a = data1;
    endcase
    unique case (fb_sel)
      FWD_EX_MEM: op_b_fwd = forward_ex_mem;
      FWD_MEM_WB: op_b_fwd = forward_mem_wb;
      default:    op_b_fwd = data2;
    endcase
    op_b = control_in.ALUSrc ? immediate_data : op_b_fwd;
  end

  logic [XLEN-1:0] alu_res;
  logic [SW-1:0]   shamt;
  assign shamt = op_b[SW-1:0];

  always_comb begin
    unique case (control_in.ALUOp)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SRL:  alu_res = op_a >> shamt;
      ALU_SRA:  alu_res = $signed(op_a) >>> shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}},
                           $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      default:  alu_res = op_a + op_b;
    endcase
  end

  logic            md_done;
  logic [XLEN-1:0] md_res;

  // M ops take the forwarded register operands, never the immediate.
  muldiv_unit #(.XLEN(XLEN)) u_md (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (flush),
    .start_i  (md_en),
    .op_i     (md_op_e'(md_op)),
    .a_i      (op_a),
    .b_i      (op_b_fwd),
    .stall_o  (stall),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_res)
  );

  assign alu_data    = md_done ? md_res : alu_res;
  assign ZeroFlag    = alu_data == '0;
  assign memory_data = op_b_fwd;
  assign rd_out      = rd_in;
  assign pc_out      = pc;

  // Bubble into EX/MEM while the M unit holds the stage.
  always_comb begin
    control_out = control_in;
    if (stall) begin
      control_out.RegWrite = 1'b0;
      control_out.MemWrite = 1'b0;
      control_out.MemRead  = 1'b0;
    end
  end

endmodule

// File: doc/execute_stage_md.md
Name: execute_stage_md

Overview:
- Parametrised successor to the single-cycle execute stage; adds an iterative RV32M multiply/divide unit.
- ALU ops and forwarding keep zero latency. M-extension ops hold the pipeline with `stall` until the result is ready.
- Sits between the ID/EX and EX/MEM registers. `stall` feeds the hazard unit, which freezes PC, IF/ID and ID/EX and inserts a bubble into EX/MEM.

Parameters:
- XLEN, 32, datapath width (≥8, even).
- REG_ADDR_W, 5, register index width.

Ports:
- clk input 1 clock
- rst input 1 async active-high reset
- flush input 1 kill the in-flight M op (branch/trap)
- pc input XLEN instruction PC
- control_in input control_type decoded control, including ALUOp, ALUSrc, RegWrite
- md_en input 1 instruction is an M-extension op
- md_op input 3 RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
- data1, data2 input XLEN register-file operands
- immediate_data input XLEN immediate
- rd_in, rs1, rs2 input REG_ADDR_W register indices
- ex_mem_rd, mem_wb_rd input REG_ADDR_W downstream destinations
- ex_mem_RegWrite, mem_wb_RegWrite input 1 downstream write enables
- forward_ex_mem, forward_mem_wb input XLEN forwarded values
- control_out output control_type control passed to EX/MEM
- ZeroFlag output 1 ALU result == 0
- alu_data output XLEN ALU or M-unit result
- memory_data output XLEN store data, forwarded rs2 value
- rd_out output REG_ADDR_W destination
- pc_out output XLEN PC passthrough
- stall output 1 EX occupied by an unfinished M op
- md_busy output 1 FSM not IDLE (debug/perf counter)

Behaviour:
- Operand select:
  - Forwarding priority is EX/MEM over MEM/WB over register file; x0 is never forwarded.
  - ALUSrc replaces the right ALU operand with the immediate, after forwarding.
  - memory_data is the forwarded rs2 value, never the immediate.
- Non-M path (md_en=0): purely combinational as before; stall=0.
- FSM states IDLE, BUSY, DONE; reset state is IDLE with all internal registers cleared.
- IDLE:
  - If md_en=1, stall=1 combinationally in the same cycle.
  - Latch the forwarded operands (not the raw register-file values), md_op, and sign flags.
  - Load counter=XLEN-1, then go to BUSY.
- BUSY:
  - One bit per cycle: shift-add multiply on a 2·XLEN product, restoring divide on magnitudes.
  - stall=1.
  - When counter=0, go to DONE; otherwise decrement the counter.
- DONE:
  - Apply sign correction and select the result: low/high product, quotient or remainder.
  - Drive alu_data; stall=0; go to IDLE.
  - ZeroFlag reflects alu_data.
- Latency:
  - M op issued at cycle T delivers its result at T+XLEN+1 (34 cycles for XLEN=32).
  - stall is high from T through T+XLEN.
- Upstream holds ID/EX stable while stall=1. Forwarding sources may change during a stall; only the latched operands are used.
- While stalled, control_out.RegWrite/MemWrite/MemRead are forced to 0 so EX/MEM receives a bubble. All other outputs pass through unchanged.
- DIV/DIVU by zero: quotient = all ones; REM/REMU result = dividend.
- Signed overflow (−2^(XLEN−1) ÷ −1): quotient = −2^(XLEN−1), remainder = 0.
- MULHSU: rs1 is signed, rs2 is unsigned.
- flush in any state: FSM returns to IDLE next cycle, no result is delivered, stall drops the following cycle. flush has priority over start.
- rst asserted mid-operation: immediate return to IDLE; stall=0, md_busy=0; counter and accumulators are cleared.
- Back-to-back M ops: the next op is accepted in the cycle after DONE (IDLE sees the new md_en).

Optional Feature:
- Macro MD_FAST_MUL_EN.
- Defined:
  - MUL* ops use a single combinational 2·XLEN multiply captured in IDLE, then go directly to DONE (latency 1 extra cycle, stall for 1 cycle).
  - Divides stay iterative.
- Undefined: all M ops are iterative as specified above.

Decomposition:
- Shared package (common) holds:
  - md_op_e enum of the funct3 encodings.
  - md_state_e {IDLE, BUSY, DONE}.
  - MD_DIV_ZERO_Q constant (all ones).
  - The existing mux_control_type for the forwarding selects.
- One sub-module, muldiv_unit: FSM, counter, accumulators, and the start/flush/done/result interface.
- Reuse the existing alu and forwarding_unit unchanged.

Test Plan:
- ADD, data1=5, data2=7, no hazards → alu_data=12 same cycle; stall=0.
- MUL rs1=7 (forwarded from EX/MEM, value 7), rs2=−3 → stall high 33 cycles, then alu_data=0xFFFFFFEB; forward_ex_mem changed mid-op does not alter the result.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0; DIVU 100/0 → 0xFFFFFFFF; REMU 100/0 → 100.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- flush at cycle 10 of a DIV → no result; stall=0 the next cycle; the following MUL 3×4 → 12.
- rst pulsed at cycle 5 of a MUL → stall=0, md_busy=0 immediately; with MD_FAST_MUL_EN, MUL 6×7 gives 42 after 1 stall cycle.
